// File: rtl/std_linear_sec_scrubber_pkg.sv
// Shared types and constants for the linear SEC memory scrubber.
package std_linear_sec_scrubber_pkg;

    localparam int CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/std_linear_sec_decoder.sv
// Hamming SEC decoder: the syndrome names the flipped bit position, zero means clean.
module std_linear_sec_decoder #(
    parameter int P = 4
) (
    input  logic [2**P-2:0]       i_code,
    output logic [(2**P-1)-P-1:0] o_data,
    output logic                  o_corrected
);
    localparam int K = 2**P - 1;

    logic [K-1:0] cover_m [P];
    logic [P-1:0] syndrome;
    logic [K-1:0] fixed;

    genvar gi, gj;
    generate
        for (gi = 0; gi < P; gi++) begin : g_syn
            for (gj = 0; gj < K; gj++) begin : g_bit
                assign cover_m[gi][gj] = 1'(((gj + 1) >> gi) & 1);
            end
            assign syndrome[gi] = ^(i_code & cover_m[gi]);
        end
        for (gi = 0; gi < K; gi++) begin : g_fix
            assign fixed[gi] = i_code[gi] ^ (syndrome == P'(gi + 1));
            if (((gi + 1) & gi) != 0) begin : g_dat
                assign o_data[gi - $clog2(gi + 2)] = fixed[gi];
            end
        end
    endgenerate

    assign o_corrected = |syndrome;

endmodule

// File: rtl/std_linear_sec_encoder.sv
// Hamming SEC encoder: codeword bit j holds position j+1, check bits sit at power-of-two positions.
module std_linear_sec_encoder #(
    parameter int P = 4
) (
    input  logic [(2**P-1)-P-1:0] i_data,
    output logic [2**P-2:0]       o_code
);
    localparam int K = 2**P - 1;

    logic [K-1:0] spread;
    logic [K-1:0] cover_m [P];

    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : g_spread
            if (((gi + 1) & gi) == 0) begin : g_chk
                assign spread[gi] = 1'b0;
            end else begin : g_dat
                assign spread[gi] = i_data[gi - $clog2(gi + 2)];
            end
        end
        for (gi = 0; gi < P; gi++) begin : g_cover
            for (gj = 0; gj < K; gj++) begin : g_bit
                assign cover_m[gi][gj] = 1'(((gj + 1) >> gi) & 1);
            end
        end
        for (gi = 0; gi < K; gi++) begin : g_code
            if (((gi + 1) & gi) == 0) begin : g_chk
                assign o_code[gi] = ^(spread & cover_m[$clog2(gi + 1)]);
            end else begin : g_dat
                assign o_code[gi] = spread[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/std_linear_sec_scrubber.sv
// Sweeps every memory word once per start request, rewriting any word the SEC decoder had to fix.
module std_linear_sec_scrubber
    import std_linear_sec_scrubber_pkg::*;
#(
    parameter int P          = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [2**P-2:0]       o_mem_wdata,
    input  logic                  i_mem_ready,
    input  logic [2**P-2:0]       i_mem_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_corr_count,
    output logic [ADDR_WIDTH-1:0] o_last_err_addr
);
    localparam int K = 2**P - 1;
    localparam int N = K - P;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] last_reg, last_next;
    logic [K-1:0]          data_reg, data_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;

    logic [N-1:0] dec_data;
    logic         dec_corrected;
    logic [K-1:0] enc_code;
    logic         last_word;

    std_linear_sec_decoder #(.P(P)) u_dec (
        .i_code      (data_reg),
        .o_data      (dec_data),
        .o_corrected (dec_corrected)
    );

    std_linear_sec_encoder #(.P(P)) u_enc (
        .i_data (dec_data),
        .o_code (enc_code)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            last_reg  <= '0;
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            last_reg  <= last_next;
            data_reg  <= data_next;
            count_reg <= count_next;
        end
    end

    assign last_word = (addr_reg == '1);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        last_next  = last_reg;
        data_next  = data_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_READ;
                    addr_next  = '0;
                end
            end
            ST_READ: begin
                if (i_mem_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                data_next  = i_mem_rdata;
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (dec_corrected) begin
                    state_next = ST_WRITE;
                    last_next  = addr_reg;
                    if (count_reg != '1) count_next = count_reg + CNT_WIDTH'(1);
                end else begin
                    state_next = last_word ? ST_DONE : ST_READ;
                    if (!last_word) addr_next = addr_reg + ADDR_WIDTH'(1);
                end
            end
            ST_WRITE: begin
                if (i_mem_ready) begin
                    state_next = last_word ? ST_DONE : ST_READ;
                    if (!last_word) addr_next = addr_reg + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // data_reg is frozen during WRITE, so the re-encoded word stays stable until granted
    always_comb begin
        o_mem_req       = (state_reg == ST_READ) || (state_reg == ST_WRITE);
        o_mem_we        = (state_reg == ST_WRITE);
        o_mem_addr      = addr_reg;
        o_mem_wdata     = enc_code;
        o_busy          = (state_reg != ST_IDLE);
        o_done          = (state_reg == ST_DONE);
        o_corr_count    = count_reg;
        o_last_err_addr = last_reg;
    end

endmodule

// File: tb/tb_std_linear_sec_scrubber.sv
// Directed bench for the SEC scrubber with a 4-word memory model and per-address bit-flip injection.
module tb_std_linear_sec_scrubber;

    localparam int P  = 4;
    localparam int AW = 2;
    localparam int K  = 2**P - 1;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [K-1:0]  o_mem_wdata;
    logic          i_mem_ready;
    logic [K-1:0]  i_mem_rdata;
    logic          o_busy;
    logic          o_done;
    logic [15:0]   o_corr_count;
    logic [AW-1:0] o_last_err_addr;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int           n_rd;
    int           n_wr;
    logic [AW-1:0] wr_addr;
    logic [K-1:0]  wr_data;
    logic [7:0]    rd_seq;
    logic [K-1:0]  inj [4];

    std_linear_sec_scrubber #(.P(P), .ADDR_WIDTH(AW)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_ready     (i_mem_ready),
        .i_mem_rdata     (i_mem_rdata),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_corr_count    (o_corr_count),
        .o_last_err_addr (o_last_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-encoded Hamming(15,11) codewords
    function automatic logic [K-1:0] rom(input logic [AW-1:0] a);
        case (a)
            2'd0:    rom = 15'h0007;
            2'd1:    rom = 15'h0019;
            2'd2:    rom = 15'h7FFF;
            default: rom = 15'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (o_mem_req && i_mem_ready) begin
            if (o_mem_we) begin
                n_wr    <= n_wr + 1;
                wr_addr <= o_mem_addr;
                wr_data <= o_mem_wdata;
                $display("mem write addr=%0d data=%h", o_mem_addr, o_mem_wdata);
            end else begin
                n_rd        <= n_rd + 1;
                rd_seq      <= {rd_seq[5:0], o_mem_addr};
                i_mem_rdata <= rom(o_mem_addr) ^ inj[o_mem_addr];
                $display("mem read  addr=%0d data=%h", o_mem_addr, rom(o_mem_addr) ^ inj[o_mem_addr]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One sweep; optional read stall on stall_addr and an ignored i_start pulse at cycle poke_at.
    task automatic sweep(input int stall_addr, input int stall_len, input int poke_at,
                         output int done_at, output int n_done);
        int left;
        int base;
        left    = stall_len;
        done_at = -1;
        n_done  = 0;
        @(negedge clk);
        i_start = 1'b1;
        base    = cyc;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            i_start     = (k == poke_at);
            i_mem_ready = 1'b1;
            if (o_done) begin
                n_done++;
                if (done_at < 0) done_at = cyc - base;
            end
            if (o_mem_req && !o_mem_we && int'(o_mem_addr) == stall_addr && left > 0) begin
                check("stall_hold", {o_mem_req, 29'd0, o_mem_addr}, {1'b1, 29'd0, 2'(stall_addr)});
                i_mem_ready = 1'b0;
                left--;
            end
        end
        i_start = 1'b0;
        $display("sweep done_at=%0d dones=%0d count=%0h last_err=%0d", done_at, n_done, o_corr_count, o_last_err_addr);
    endtask

    initial begin
        int d, nd, w0, r0, found;
        foreach (inj[i]) inj[i] = '0;
        i_rst       = 1'b1;
        i_start     = 1'b1;
        i_mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_req", o_mem_req, 0);
        check("rst_we", o_mem_we, 0);
        check("rst_done", o_done, 0);
        check("rst_count", o_corr_count, 0);
        check("rst_last", o_last_err_addr, 0);
        i_rst   = 1'b0;
        i_start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", o_busy, 0);

        // Clean sweep
        w0 = n_wr; r0 = n_rd;
        sweep(99, 0, 0, d, nd);
        check("clean_done_cycle", d, 13);
        check("clean_done_pulses", nd, 1);
        check("clean_writes", n_wr - w0, 0);
        check("clean_reads", n_rd - r0, 4);
        check("clean_read_order", rd_seq, 8'h1B);
        check("clean_count", o_corr_count, 0);

        // Bit 5 flipped at address 2
        inj[2] = 15'h0020;
        w0 = n_wr;
        sweep(99, 0, 0, d, nd);
        inj[2] = '0;
        check("corr_done_cycle", d, 14);
        check("corr_writes", n_wr - w0, 1);
        check("corr_wr_addr", wr_addr, 2);
        check("corr_wr_data", wr_data, 15'h7FFF);
        check("corr_count", o_corr_count, 1);
        check("corr_last", o_last_err_addr, 2);

        // Three-cycle grant stall on the read of address 1
        w0 = n_wr;
        sweep(1, 3, 0, d, nd);
        check("stall_done_cycle", d, 16);
        check("stall_writes", n_wr - w0, 0);
        check("persist_count", o_corr_count, 1);
        check("persist_last", o_last_err_addr, 2);

        // Start while busy is ignored, then a second full sweep
        sweep(99, 0, 5, d, nd);
        check("poke_done_pulses", nd, 1);
        check("poke_done_cycle", d, 13);
        r0 = n_rd;
        sweep(99, 0, 0, d, nd);
        check("second_done_cycle", d, 13);
        check("second_reads", n_rd - r0, 4);

        // Reset while a write is pending and ungranted
        inj[0] = 15'h0001;
        w0 = n_wr;
        found = 0;
        @(negedge clk);
        i_start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_mem_req && o_mem_we) begin
                found = 1;
                break;
            end
        end
        check("write_reached", found, 1);
        check("write_addr", o_mem_addr, 0);
        check("write_wdata", o_mem_wdata, 15'h0007);
        check("count_in_write", o_corr_count, 2);
        i_mem_ready = 1'b0;
        i_rst       = 1'b1;
        @(negedge clk);
        check("wrst_busy", o_busy, 0);
        check("wrst_req", o_mem_req, 0);
        check("wrst_done", o_done, 0);
        check("wrst_count", o_corr_count, 0);
        check("wrst_last", o_last_err_addr, 0);
        check("wrst_no_write", n_wr - w0, 0);
        i_rst       = 1'b0;
        i_mem_ready = 1'b1;
        inj[0]      = '0;
        @(negedge clk);
        check("wrst_stays_idle", o_busy, 0);

        // Saturation: preload the counter just below the ceiling
        force dut.count_reg = 16'hFFFD;
        @(negedge clk);
        release dut.count_reg;
        @(negedge clk);
        check("preload_count", o_corr_count, 16'hFFFD);
        inj[0] = 15'h0001;
        inj[1] = 15'h0002;
        inj[2] = 15'h4000;
        inj[3] = 15'h0080;
        w0 = n_wr;
        sweep(99, 0, 0, d, nd);
        check("sat_done_cycle", d, 17);
        check("sat_writes", n_wr - w0, 4);
        check("sat_wr_data", wr_data, 15'h0000);
        check("sat_count", o_corr_count, 16'hFFFF);
        check("sat_last", o_last_err_addr, 3);
        sweep(99, 0, 0, d, nd);
        check("sat_count_hold", o_corr_count, 16'hFFFF);
        foreach (inj[i]) inj[i] = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
